// File: rtl/tx_dma_axis_if.sv
// Read-request/response channel and tx AXIS stream of the tx DMA engine.
interface tx_dma_axis_if #(
    parameter int paddr_width_p = 40
) ();
    logic [paddr_width_p-1:0] rd_addr_o;
    logic                     rd_v_o;
    logic                     rd_yumi_i;
    logic [63:0]              rd_data_i;
    logic                     rd_data_v_i;
    logic                     rd_data_ready_o;
    logic [63:0]              tx_axis_tdata_o;
    logic [7:0]               tx_axis_tkeep_o;
    logic                     tx_axis_tvalid_o;
    logic                     tx_axis_tready_i;
    logic                     tx_axis_tlast_o;
    logic                     tx_axis_tuser_o;

    modport master (
        output rd_addr_o, rd_v_o, rd_data_ready_o,
        input  rd_yumi_i, rd_data_i, rd_data_v_i,
        output tx_axis_tdata_o, tx_axis_tkeep_o,
        output tx_axis_tvalid_o, tx_axis_tlast_o,
        output tx_axis_tuser_o,
        input  tx_axis_tready_i
    );

    modport slave (
        input  rd_addr_o, rd_v_o, rd_data_ready_o,
        output rd_yumi_i, rd_data_i, rd_data_v_i,
        input  tx_axis_tdata_o, tx_axis_tkeep_o,
        input  tx_axis_tvalid_o, tx_axis_tlast_o,
        input  tx_axis_tuser_o,
        output tx_axis_tready_i
    );
endinterface

// File: rtl/tx_dma_axis.sv
// Tx DMA: fetches a frame by dword reads and streams it on tx AXIS.
// Optional short-frame padding to 60 bytes when TX_DMA_PAD_EN is defined.
module tx_dma_axis #(
    parameter int paddr_width_p     = 40,
    parameter int eth_cmd_width_p   = 3,
    parameter int max_frame_bytes_p = 1536,
    parameter int max_credits_p     = 8
) (
    input  logic                       clk_i,
    input  logic                       reset_i,
    input  logic [eth_cmd_width_p-1:0] eth_cmd_i,
    input  logic                       eth_cmd_v_i,
    input  logic [paddr_width_p-1:0]   eth_cmd_arg_i,
    output logic [1:0]                 tx_ext_state_o,
    tx_dma_axis_if.master              bus
);
    localparam int len_w_lp  = $clog2(max_frame_bytes_p + 1);
    localparam int cred_w_lp = $clog2(max_credits_p + 1);
    localparam int ptr_w_lp  = $clog2(max_credits_p);

    typedef enum logic [1:0] {
        S_IDLE, S_FETCH, S_DRAIN, S_DONE
    } state_e;

    state_e                   state_q, state_d;
    logic [len_w_lp-1:0]      len_q, len_d;
    logic [paddr_width_p-1:0] addr_q, addr_d;
    logic [len_w_lp-1:0]      nread_q, nread_d;
    logic [len_w_lp-1:0]      nout_q, nout_d;
    logic [len_w_lp-1:0]      issued_q, issued_d;
    logic [len_w_lp-1:0]      sent_q, sent_d;
    logic [cred_w_lp-1:0]     credits_q, credits_d;
    logic [cred_w_lp-1:0]     infl_q, infl_d;
    logic [cred_w_lp-1:0]     cnt_q, cnt_d;
    logic [ptr_w_lp-1:0]      wptr_q, wptr_d;
    logic [ptr_w_lp-1:0]      rptr_q, rptr_d;
    logic [1:0]               ext_q, ext_d;
    logic [63:0]              mem_q [max_credits_p];

    logic                cmd_set, cmd_start, cmd_ack;
    logic [len_w_lp-1:0] arg_len, nread_c, nout_c;
    logic [len_w_lp:0]   len_p7;
    logic                busy, fifo_v, local_beat;
    logic                tvalid, pop, fifo_pop;
    logic                issue, push, rd_v, last_beat;
    logic [7:0]          rem_mask, keep_last;
    logic [63:0]         head, data_c;

    assign cmd_set   = eth_cmd_v_i &&
                       eth_cmd_i == eth_cmd_width_p'(1);
    assign cmd_start = eth_cmd_v_i &&
                       eth_cmd_i == eth_cmd_width_p'(2);
    assign cmd_ack   = eth_cmd_v_i &&
                       eth_cmd_i == eth_cmd_width_p'(3);

    assign arg_len =
        (eth_cmd_arg_i > paddr_width_p'(max_frame_bytes_p))
        ? len_w_lp'(max_frame_bytes_p)
        : eth_cmd_arg_i[len_w_lp-1:0];

    assign len_p7  = {1'b0, len_q} + (len_w_lp + 1)'(7);
    assign nread_c = len_w_lp'(len_p7[len_w_lp:3]);

`ifdef TX_DMA_PAD_EN
    logic                pad_short;
    logic [len_w_lp+2:0] base_c;
    assign pad_short = len_q < len_w_lp'(60);
    assign nout_c    = pad_short ? len_w_lp'(8) : nread_c;
`else
    assign nout_c    = nread_c;
`endif

    assign busy   = state_q == S_FETCH || state_q == S_DRAIN;
    assign fifo_v = cnt_q != '0;
    // Pad beats follow once every fetched beat has left the FIFO.
    assign local_beat = busy && sent_q >= nread_q &&
                        sent_q < nout_q;
    assign tvalid    = fifo_v || local_beat;
    assign pop       = tvalid && bus.tx_axis_tready_i;
    assign fifo_pop  = pop && fifo_v;
    assign last_beat = sent_q == nout_q - len_w_lp'(1);

    assign rd_v  = state_q == S_FETCH && issued_q < nread_q &&
                   credits_q < cred_w_lp'(max_credits_p);
    assign issue = rd_v && bus.rd_yumi_i;
    // Responses with no request in flight predate a reset.
    assign push  = bus.rd_data_v_i && infl_q != '0;

    assign rem_mask = (len_q[2:0] == 3'd0) ? 8'hFF
                    : (8'h01 << len_q[2:0]) - 8'h01;
`ifdef TX_DMA_PAD_EN
    assign keep_last = pad_short ? 8'h0F : rem_mask;
`else
    assign keep_last = rem_mask;
`endif

    assign head = fifo_v ? mem_q[rptr_q] : 64'h0;

    always_comb begin
        data_c = head;
`ifdef TX_DMA_PAD_EN
        base_c = {sent_q, 3'b000};
        for (int k = 0; k < 8; k++) begin
            if (base_c + (len_w_lp + 3)'(k) >=
                (len_w_lp + 3)'(len_q))
                data_c[8*k +: 8] = 8'h00;
        end
`endif
    end

    assign bus.rd_addr_o        = addr_q;
    assign bus.rd_v_o           = rd_v;
    assign bus.rd_data_ready_o  = 1'b1;
    assign bus.tx_axis_tvalid_o = tvalid;
    assign bus.tx_axis_tdata_o  = tvalid ? data_c : 64'h0;
    assign bus.tx_axis_tkeep_o  = !tvalid  ? 8'h00
                                : last_beat ? keep_last
                                : 8'hFF;
    assign bus.tx_axis_tlast_o  = tvalid && last_beat;
    assign bus.tx_axis_tuser_o  = 1'b0;
    assign tx_ext_state_o       = ext_q;

    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        addr_d    = addr_q;
        nread_d   = nread_q;
        nout_d    = nout_q;
        issued_d  = issued_q;
        sent_d    = sent_q;
        credits_d = credits_q + cred_w_lp'(issue)
                  - cred_w_lp'(fifo_pop);
        infl_d    = infl_q + cred_w_lp'(issue)
                  - cred_w_lp'(push);
        cnt_d     = cnt_q + cred_w_lp'(push)
                  - cred_w_lp'(fifo_pop);
        wptr_d    = wptr_q;
        rptr_d    = rptr_q;
        if (push)
            wptr_d = (wptr_q == ptr_w_lp'(max_credits_p - 1))
                   ? '0 : wptr_q + ptr_w_lp'(1);
        if (fifo_pop)
            rptr_d = (rptr_q == ptr_w_lp'(max_credits_p - 1))
                   ? '0 : rptr_q + ptr_w_lp'(1);

        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (cmd_set)
                    len_d = arg_len;
                if (cmd_start) begin
                    addr_d   = {eth_cmd_arg_i[paddr_width_p-1:3],
                                3'b000};
                    nread_d  = nread_c;
                    nout_d   = nout_c;
                    issued_d = '0;
                    sent_d   = '0;
                    state_d  = (len_q == '0) ? S_DONE : S_FETCH;
                end else if (cmd_ack && state_q == S_DONE) begin
                    state_d = S_IDLE;
                end
            end
            S_FETCH: begin
                if (issue) begin
                    addr_d   = addr_q + paddr_width_p'(8);
                    issued_d = issued_q + len_w_lp'(1);
                end
                if (issued_d == nread_q)
                    state_d = S_DRAIN;
            end
            default: ;
        endcase

        if (pop) begin
            sent_d = sent_q + len_w_lp'(1);
            if (last_beat)
                state_d = S_DONE;
        end

        unique case (state_d)
            S_IDLE:  ext_d = 2'd0;
            S_DONE:  ext_d = 2'd2;
            default: ext_d = 2'd1;
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q   <= S_IDLE;
            len_q     <= '0;
            addr_q    <= '0;
            nread_q   <= '0;
            nout_q    <= '0;
            issued_q  <= '0;
            sent_q    <= '0;
            credits_q <= '0;
            infl_q    <= '0;
            cnt_q     <= '0;
            wptr_q    <= '0;
            rptr_q    <= '0;
            ext_q     <= 2'd0;
        end else begin
            state_q   <= state_d;
            len_q     <= len_d;
            addr_q    <= addr_d;
            nread_q   <= nread_d;
            nout_q    <= nout_d;
            issued_q  <= issued_d;
            sent_q    <= sent_d;
            credits_q <= credits_d;
            infl_q    <= infl_d;
            cnt_q     <= cnt_d;
            wptr_q    <= wptr_d;
            rptr_q    <= rptr_d;
            ext_q     <= ext_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push)
            mem_q[wptr_q] <= bus.rd_data_i;
    end
endmodule

// File: tb/tb_tx_dma_axis.sv
// Randomized bench for tx_dma_axis against a frame-level reference model.
// Padding expectations follow TX_DMA_PAD_EN when it is defined.
module tb_tx_dma_axis;
    typedef struct {
        logic [39:0] addr;
        int          due;
    } req_t;

    typedef struct {
        logic [63:0] d;
        logic [7:0]  k;
        logic        l;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [2:0]  cmd = 3'd0;
    logic        cmd_v = 1'b0;
    logic [39:0] arg = 40'h0;
    logic [1:0]  st;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;
    int n_req  = 0;
    int n_pop  = 0;
    int rdy_pct  = 100;
    int yumi_pct = 100;
    int resp_dly = 0;
    int mlen     = 0;

    logic [39:0] exp_addr[$];
    beat_t       exp_beats[$];
    req_t        pend[$];

    tx_dma_axis_if bus ();

    tx_dma_axis dut (
        .clk_i          (clk),
        .reset_i        (rst),
        .eth_cmd_i      (cmd),
        .eth_cmd_v_i    (cmd_v),
        .eth_cmd_arg_i  (arg),
        .tx_ext_state_o (st),
        .bus            (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] memword(logic [39:0] a);
        return {a[31:0] ^ 32'h5A3C_96E1, a[31:0] * 32'h9E37_79B9};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Memory and AXIS sink; acts on the falling edge.
    initial begin
        req_t  r;
        beat_t b;
        bus.rd_yumi_i        = 1'b0;
        bus.rd_data_i        = 64'h0;
        bus.rd_data_v_i      = 1'b0;
        bus.tx_axis_tready_i = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                pend.delete();
                bus.rd_yumi_i        = 1'b0;
                bus.rd_data_v_i      = 1'b0;
                bus.rd_data_i        = 64'h0;
                bus.tx_axis_tready_i = 1'b0;
            end else begin
                if (pend.size() != 0 && pend[0].due <= cyc) begin
                    r = pend.pop_front();
                    bus.rd_data_v_i = 1'b1;
                    bus.rd_data_i   = memword(r.addr);
                end else begin
                    bus.rd_data_v_i = 1'b0;
                    bus.rd_data_i   = 64'h0;
                end
                bus.rd_yumi_i = bus.rd_v_o &&
                                ($urandom % 100 < yumi_pct);
                if (bus.rd_yumi_i) begin
                    chk("rd_expected", exp_addr.size() != 0, 1);
                    if (exp_addr.size() != 0)
                        chk("rd_addr", bus.rd_addr_o,
                            exp_addr.pop_front());
                    r.addr = bus.rd_addr_o;
                    r.due  = cyc + ((resp_dly > 0) ? resp_dly
                                    : $urandom_range(1, 6));
                    pend.push_back(r);
                    n_req++;
                end
                bus.tx_axis_tready_i = ($urandom % 100 < rdy_pct);
                if (bus.tx_axis_tvalid_o && bus.tx_axis_tready_i) begin
                    chk("beat_expected", exp_beats.size() != 0, 1);
                    if (exp_beats.size() != 0) begin
                        b = exp_beats.pop_front();
                        chk("tdata", bus.tx_axis_tdata_o, b.d);
                        chk("tkeep", bus.tx_axis_tkeep_o, b.k);
                        chk("tlast", bus.tx_axis_tlast_o, b.l);
                    end
                    n_pop++;
                end
            end
        end
    end

    task automatic expect_frame(input logic [39:0] a);
        logic [39:0] base;
        logic [63:0] w;
        beat_t       b;
        int          nread, nout, rem, pad;
        base  = {a[39:3], 3'b000};
        nread = (mlen + 7) / 8;
        pad   = 0;
`ifdef TX_DMA_PAD_EN
        pad   = 1;
`endif
        nout  = (pad != 0 && mlen < 60) ? 8 : nread;
        rem   = mlen % 8;
        for (int i = 0; i < nread; i++)
            exp_addr.push_back(base + 40'(8 * i));
        for (int i = 0; i < nout; i++) begin
            w = (i < nread) ? memword(base + 40'(8 * i)) : 64'h0;
            for (int k = 0; k < 8; k++)
                if (pad != 0 && 8 * i + k >= mlen)
                    w[8*k +: 8] = 8'h00;
            b.d = w;
            b.l = (i == nout - 1);
            if (i != nout - 1)
                b.k = 8'hFF;
            else if (pad != 0 && mlen < 60)
                b.k = 8'h0F;
            else
                b.k = (rem == 0) ? 8'hFF : 8'((1 << rem) - 1);
            exp_beats.push_back(b);
        end
    endtask

    task automatic send_cmd(input int op, input logic [39:0] a);
        @(negedge clk);
        cmd   = 3'(op);
        arg   = a;
        cmd_v = 1'b1;
        @(negedge clk);
        cmd_v = 1'b0;
        #1;
    endtask

    task automatic set_len(input int l);
        send_cmd(1, 40'(l));
        mlen = (l > 1536) ? 1536 : l;
    endtask

    task automatic go(input logic [39:0] a);
        if (mlen > 0)
            expect_frame(a);
        send_cmd(2, a);
    endtask

    task automatic wait_state(input logic [1:0] tgt, input int budget,
                              input string tag);
        for (int i = 0; i < budget; i++) begin
            if (st == tgt)
                break;
            @(negedge clk);
            #1;
        end
        chk(tag, st, tgt);
    endtask

    task automatic wait_done(input string tag);
        wait_state(2'd2, 6000, tag);
        chk("beats_left", exp_beats.size(), 0);
        chk("reads_left", exp_addr.size(), 0);
    endtask

    task automatic ack();
        send_cmd(3, 40'h0);
        chk("ack_idle", st, 2'd0);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_rd_v"}, bus.rd_v_o, 0);
        chk({tag, "_rd_addr"}, bus.rd_addr_o, 0);
        chk({tag, "_tvalid"}, bus.tx_axis_tvalid_o, 0);
        chk({tag, "_tdata"}, bus.tx_axis_tdata_o, 0);
        chk({tag, "_tkeep"}, bus.tx_axis_tkeep_o, 0);
        chk({tag, "_tlast"}, bus.tx_axis_tlast_o, 0);
        chk({tag, "_tuser"}, bus.tx_axis_tuser_o, 0);
        chk({tag, "_state"}, st, 0);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int r0;
        int seen;
        int l;
        logic [39:0] a;

        repeat (3) @(negedge clk);
        #1;
        check_zero("reset");
        @(negedge clk);
        rst = 1'b0;

        // 64 B frame, full rate
        set_len(64);
        chk("set_len_idle", st, 2'd0);
        go(40'h1000);
        chk("start_busy", st, 2'd1);
        wait_done("frame64_done");
        ack();

        // 13 B unaligned frame
        set_len(13);
        r0 = n_req;
        go(40'h2004);
        wait_done("frame13_done");
        chk("frame13_reads", n_req - r0, 2);
        ack();

        // zero length goes straight to DONE
        set_len(0);
        r0 = n_req;
        go(40'h7000);
        chk("len0_done", st, 2'd2);
        chk("len0_reads", n_req - r0, 0);
        ack();

        // credit limit with stalled sink and slow memory
        rdy_pct  = 0;
        resp_dly = 20;
        set_len(100);
        go(40'h6000);
        repeat (15) @(negedge clk);
        #1;
        chk("outstanding", n_req - n_pop, 8);
        chk("rd_v_held", bus.rd_v_o, 0);
        rdy_pct = 100;
        seen = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            #1;
            if (bus.tx_axis_tvalid_o && bus.tx_axis_tready_i) begin
                seen = 1;
                break;
            end
        end
        chk("first_pop_seen", seen, 1);
        @(negedge clk);
        #1;
        chk("rd_v_reassert", bus.rd_v_o, 1);
        wait_done("credit_done");
        ack();
        resp_dly = 0;

        // commands during a frame are ignored
        rdy_pct  = 0;
        yumi_pct = 60;
        set_len(40);
        go(40'h3000);
        send_cmd(2, 40'h9000);
        send_cmd(1, 40'h0);
        chk("mid_cmd_busy", st, 2'd1);
        rdy_pct = 50;
        wait_done("mid_cmd_done");
        ack();
        go(40'h4000);
        wait_done("len_kept_done");
        ack();

`ifdef TX_DMA_PAD_EN
        rdy_pct  = 100;
        yumi_pct = 100;
        set_len(20);
        r0 = n_req;
        go(40'h5100);
        wait_done("pad20_done");
        chk("pad20_reads", n_req - r0, 3);
        ack();
`endif

        // randomized frames
        for (int i = 0; i < 6; i++) begin
            rdy_pct  = $urandom_range(30, 100);
            yumi_pct = $urandom_range(30, 100);
            l = $urandom_range(1, 200);
            a = {8'h00, $urandom};
            set_len(l);
            go(a);
            wait_done("rand_done");
            ack();
        end

        // oversize length clamps to the maximum frame
        rdy_pct  = 100;
        yumi_pct = 100;
        set_len(5000);
        r0 = n_req;
        go(40'h10000);
        wait_done("clamp_done");
        chk("clamp_reads", n_req - r0, 192);
        ack();

        // reset in the middle of DRAIN
        rdy_pct = 0;
        set_len(64);
        go(40'h8000);
        repeat (20) @(negedge clk);
        #1;
        chk("pre_reset_busy", st, 2'd1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_zero("mid_reset");
        exp_addr.delete();
        exp_beats.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        rdy_pct = 100;
        set_len(8);
        go(40'h5000);
        wait_done("post_reset_done");
        ack();

        repeat (5) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
